// File: rtl/rv_fetch_mt.sv
// rv_fetch_mt: round-robin multithreaded instruction fetch with redirect and stale-fetch squash
module rv_fetch_mt #(
  parameter int          NTHREADS = 4,
  parameter int          TID_W    = $clog2(NTHREADS),
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NTHREADS-1:0] thread_en,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [31:0]         imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [TID_W-1:0]    redirect_tid,
  input  logic [31:0]         redirect_pc,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [31:0]         if_inst,
  output logic [31:0]         if_pc,
  output logic [TID_W-1:0]    if_tid
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_e;
  state_e state_q, state_d;
  logic [TID_W-1:0] sel_tid_q, sel_tid_d, last_tid_q, last_tid_d, next_tid;
  logic kill_q, kill_d;
  logic [31:0] pc_q [NTHREADS];
  logic [31:0] pc_d [NTHREADS];
  logic [31:0] if_inst_q, if_inst_d, if_pc_q, if_pc_d;
  logic req_hs, rd_sel;
  assign req_hs = state_q == REQ && imem_req_ready;
  assign rd_sel = redirect_valid && redirect_tid == sel_tid_q;
  // first enabled thread strictly after last_tid; the k loop runs backwards so the nearest wins
  always_comb begin
    next_tid = last_tid_q;
    for (int k = NTHREADS; k >= 1; k--)
      if (thread_en[last_tid_q + TID_W'(k)]) next_tid = last_tid_q + TID_W'(k);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next-state: a redirect of the in-flight thread squashes its response or held instruction
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = |thread_en ? REQ : IDLE;
      REQ:  state_d = imem_req_ready ? WAIT : REQ;
      WAIT: state_d = !imem_rsp_valid ? WAIT : (kill_q || rd_sel) ? IDLE : OUT;
      OUT:  state_d = (if_ready || rd_sel) ? IDLE : OUT;
    endcase
  end
  // datapath next values; a redirect beats the +4 of a same-cycle handshake
  always_comb begin
    sel_tid_d  = (state_q == IDLE && |thread_en) ? next_tid : sel_tid_q;
    last_tid_d = req_hs ? sel_tid_q : last_tid_q;
    if_pc_d    = req_hs ? imem_req_addr : if_pc_q;
    if_inst_d  = (state_q == WAIT && imem_rsp_valid && !kill_q && !rd_sel) ? imem_rsp_data : if_inst_q;
    kill_d     = (state_q == WAIT && imem_rsp_valid) ? 1'b0 :
                 ((req_hs || state_q == WAIT) && rd_sel) ? 1'b1 : kill_q;
    for (int i = 0; i < NTHREADS; i++)
      pc_d[i] = (redirect_valid && redirect_tid == TID_W'(i)) ? (redirect_pc & ~32'd3) :
                (req_hs && sel_tid_q == TID_W'(i)) ? pc_q[i] + 32'd4 : pc_q[i];
  end
  // datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel_tid_q  <= '0;
      last_tid_q <= TID_W'(NTHREADS - 1);
      kill_q     <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
      pc_q       <= '{default: RESET_PC};
    end else begin
      sel_tid_q  <= sel_tid_d;
      last_tid_q <= last_tid_d;
      kill_q     <= kill_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
      pc_q       <= pc_d;
    end
  // outputs decoded from state; sel_tid is frozen outside IDLE so it doubles as if_tid
  always_comb begin
    imem_req_valid = state_q == REQ;
    if_valid       = state_q == OUT;
    imem_req_addr  = pc_q[sel_tid_q];
    if_inst        = if_inst_q;
    if_pc          = if_pc_q;
    if_tid         = sel_tid_q;
  end
endmodule

// File: tb/tb_rv_fetch_mt.sv
// tb_rv_fetch_mt: randomized fetch traffic checked against a transaction-level thread model
module tb_rv_fetch_mt;
  localparam int N  = 4;
  localparam int TW = 2;
  logic clk, rst_n;
  logic [N-1:0] thread_en;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, if_valid, if_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, if_inst, if_pc;
  logic [TW-1:0] redirect_tid, if_tid;
  rv_fetch_mt #(.NTHREADS(N)) dut (
    .clk(clk), .rst_n(rst_n), .thread_en(thread_en),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc), .if_tid(if_tid)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // model: which thread is in flight and what stage its fetch has reached
  typedef enum {M_SEL, M_ASK, M_MEM, M_HOLD} mstage_e;
  typedef struct { logic [31:0] a; int c; } mreq_t;
  mstage_e st;
  logic [31:0] pc_m [N];
  int last_m, cur;
  bit kill_m;
  logic [31:0] out_pc;
  mreq_t mq[$];
  logic [31:0] log_pc[$];
  int log_tid[$];
  int en_mode, p_rdy, p_ifr, p_rd, lat;
  logic [N-1:0] en_fix;
  bit frc, rd_wait;
  logic [TW-1:0] frc_tid;
  logic [31:0] frc_pc;
  task automatic model_reset();
    foreach (pc_m[i]) pc_m[i] = 32'h0;
    last_m = N - 1; cur = 0; st = M_SEL; kill_m = 0; out_pc = 0;
  endtask
  task automatic knobs(input int em, input logic [N-1:0] ef, input int pr, input int pi, input int pd, input int l);
    en_mode = em; en_fix = ef; p_rdy = pr; p_ifr = pi; p_rd = pd; lat = l;
  endtask
  task automatic check_rst(input string t);
    check({t, "_req_valid"}, imem_req_valid, 0);
    check({t, "_req_addr"}, imem_req_addr, 32'h0);
    check({t, "_if_valid"}, if_valid, 0);
    check({t, "_if_inst"}, if_inst, 0);
    check({t, "_if_pc"}, if_pc, 0);
    check({t, "_if_tid"}, if_tid, 0);
  endtask
  task automatic quiet_inputs();
    thread_en = '0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_tid = '0; redirect_pc = '0; if_ready = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    quiet_inputs();
    mq.delete(); log_pc.delete(); log_tid.delete();
    model_reset();
    #1 check_rst("rst");
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic check_log(input string tag, input int i, input logic [31:0] pc, input int tid);
    check({tag, "_pc"}, i < log_pc.size() ? log_pc[i] : 32'hDEAD_BEEF, pc);
    check({tag, "_tid"}, i < log_tid.size() ? log_tid[i] : -1, tid);
  endtask
  // one clock: check outputs, drive inputs, play memory, then advance the model by the same edge
  task automatic cycle();
    bit rd;
    int rt;
    logic [31:0] rp;
    @(negedge clk);
    check("req_valid", imem_req_valid, st == M_ASK);
    if (st == M_ASK) check("req_addr", imem_req_addr, pc_m[cur]);
    check("if_valid", if_valid, st == M_HOLD);
    if (st == M_HOLD) begin
      check("if_pc", if_pc, out_pc);
      check("if_tid", if_tid, cur);
      check("if_inst", if_inst, out_pc ^ 32'hA5A5_0000);
    end
    thread_en = en_mode != 0 ? N'($urandom) : en_fix;
    imem_req_ready = $urandom_range(99) < p_rdy;
    if_ready = $urandom_range(99) < p_ifr;
    redirect_valid = $urandom_range(99) < p_rd;
    redirect_tid = TW'($urandom);
    case ($urandom_range(3))
      0: redirect_pc = 32'hFFFF_FFFC;
      1: redirect_pc = 32'h100 | $urandom_range(3);
      default: redirect_pc = $urandom;
    endcase
    if (frc) begin
      redirect_valid = 1; redirect_tid = frc_tid; redirect_pc = frc_pc; frc = 0;
    end
    if (rd_wait && st == M_MEM && cur == 0 && out_pc == 32'h8) begin
      redirect_valid = 1; redirect_tid = 0; redirect_pc = 32'h100; rd_wait = 0;
    end
    imem_rsp_valid = 0;
    if (mq.size() > 0) begin
      if (mq[0].c == 0) begin
        imem_rsp_valid = 1;
        imem_rsp_data = mq[0].a ^ 32'hA5A5_0000;
        void'(mq.pop_front());
      end else mq[0].c = mq[0].c - 1;
    end
    if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, int'($urandom_range(lat - 1))});
    if (if_valid && if_ready) begin
      log_pc.push_back(if_pc);
      log_tid.push_back(int'(if_tid));
    end
    rd = redirect_valid; rt = int'(redirect_tid); rp = redirect_pc & ~32'h3;
    case (st)
      M_SEL: if (thread_en != 0) begin
        for (int k = 1; k <= N; k++)
          if (thread_en[(last_m + k) % N]) begin cur = (last_m + k) % N; break; end
        st = M_ASK;
      end
      M_ASK: if (imem_req_ready) begin
        last_m = cur; out_pc = pc_m[cur]; kill_m = rd && rt == cur;
        pc_m[cur] = pc_m[cur] + 32'd4;
        st = M_MEM;
      end
      M_MEM: if (imem_rsp_valid) begin
        st = (kill_m || (rd && rt == cur)) ? M_SEL : M_HOLD;
        kill_m = 0;
      end else if (rd && rt == cur) kill_m = 1;
      M_HOLD: if (if_ready || (rd && rt == cur)) st = M_SEL;
    endcase
    if (rd) pc_m[rt] = rp;
  endtask
  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
  initial begin
    rst_n = 0; quiet_inputs(); model_reset(); frc = 0; rd_wait = 0;
    knobs(0, 4'b0001, 100, 100, 0, 1);
    do_reset();
    repeat (20) cycle();
    check_log("st0", 0, 32'h0, 0);
    check_log("st1", 1, 32'h4, 0);
    check_log("st2", 2, 32'h8, 0);
    knobs(0, 4'b1011, 100, 100, 0, 1);
    do_reset();
    repeat (30) cycle();
    check_log("rr0", 0, 32'h0, 0);
    check_log("rr1", 1, 32'h0, 1);
    check_log("rr2", 2, 32'h0, 3);
    check_log("rr3", 3, 32'h4, 0);
    check_log("rr4", 4, 32'h4, 1);
    check_log("rr5", 5, 32'h4, 3);
    knobs(0, 4'b0001, 100, 100, 0, 3);
    do_reset();
    rd_wait = 1;
    repeat (40) cycle();
    check_log("rdw0", 0, 32'h0, 0);
    check_log("rdw1", 1, 32'h4, 0);
    check_log("rdw2", 2, 32'h100, 0);
    knobs(0, 4'b0010, 100, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 20 && !if_valid; i++) cycle();
    check("bp_reach", if_valid, 1);
    repeat (5) cycle();
    frc = 1; frc_tid = 1; frc_pc = 32'h40;
    repeat (4) cycle();
    check("bp_none", log_pc.size(), 0);
    p_ifr = 100;
    repeat (12) cycle();
    check_log("bp", 0, 32'h40, 1);
    knobs(0, 4'b0001, 100, 100, 0, 2);
    do_reset();
    cycle();
    frc = 1; frc_tid = 0; frc_pc = 32'h200;
    repeat (16) cycle();
    check_log("hsrd0", 0, 32'h200, 0);
    check_log("hsrd1", 1, 32'h204, 0);
    knobs(0, 4'b0001, 100, 100, 0, 1);
    do_reset();
    frc = 1; frc_tid = 0; frc_pc = 32'hFFFF_FFFE;
    repeat (12) cycle();
    check_log("wrap0", 0, 32'hFFFF_FFFC, 0);
    check_log("wrap1", 1, 32'h0, 0);
    knobs(0, 4'b0000, 100, 100, 0, 1);
    repeat (10) cycle();
    check("idle_req", imem_req_valid, 0);
    knobs(0, 4'b0001, 100, 100, 0, 3);
    do_reset();
    for (int i = 0; i < 40 && !(st == M_MEM && out_pc == 32'h4); i++) cycle();
    check("arst_reach", imem_req_valid, 1);
    @(posedge clk);
    #2 rst_n = 0;
    quiet_inputs();
    #1 check_rst("arst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset(); log_pc.delete(); log_tid.delete();
    knobs(0, 4'b0000, 100, 100, 0, 3);
    repeat (5) cycle();
    check("arst_drained", mq.size(), 0);
    knobs(0, 4'b0001, 100, 100, 0, 1);
    repeat (12) cycle();
    check_log("arst0", 0, 32'h0, 0);
    check_log("arst1", 1, 32'h4, 0);
    knobs(1, 4'b0000, 60, 60, 15, 3);
    do_reset();
    repeat (3000) cycle();
    knobs(1, 4'b0000, 80, 40, 40, 2);
    repeat (2000) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
